// File: rtl/maxpool2x2_pe_pkg.sv
// Shared defaults and helpers for the 2x2 stride-2 max-pool stage.
// Frame geometry defaults come from the build config defines when present.
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 16
`endif
`ifndef POOL_FMAP_W
`define POOL_FMAP_W 8
`endif
`ifndef POOL_FMAP_H
`define POOL_FMAP_H 8
`endif

package maxpool2x2_pe_pkg;

  localparam int DEF_DATA_W = `OUTPUT_BUF_DATASIZE;
  localparam int DEF_FMAP_W = `POOL_FMAP_W;
  localparam int DEF_FMAP_H = `POOL_FMAP_H;

  localparam logic MODE_POOL   = 1'b1;
  localparam logic MODE_BYPASS = 1'b0;

  // Counter width that never collapses to zero bits for tiny frames.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maxpool2x2_pe_line_buf.sv
// Half-row line buffer: holds the horizontal pair maxima of an even row until
// the matching odd row arrives. Synchronous write, asynchronous read, no reset.
module pool_line_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[addr];

endmodule

// File: rtl/maxpool2x2_pe.sv
// Streaming 2x2 stride-2 max-pool (or bypass) on a row-major feature map; one
// result register, 1-cycle latency, in_ready = !out_valid || out_ready.
module maxpool2x2_pe
  import maxpool2x2_pe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FMAP_W = DEF_FMAP_W,
  parameter int FMAP_H = DEF_FMAP_H
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pool_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int COL_W  = cnt_w(FMAP_W);
  localparam int ROW_W  = cnt_w(FMAP_H);
  localparam int ADDR_W = cnt_w(FMAP_W / 2);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FMAP_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FMAP_H - 1);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] pair_q, pair_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic              accept, frame_start, mode_cur, col_last, row_last;
  logic              load, lb_we;
  logic [DATA_W-1:0] result;
  logic [ADDR_W-1:0] lb_addr;
  logic [DATA_W-1:0] lb_rd;
  logic signed [DATA_W-1:0] pair_max, win_max;

  assign in_ready    = !out_valid_q || out_ready;
  assign accept      = in_valid && in_ready;
  assign frame_start = (row_q == '0) && (col_q == '0);
  // The first sample of a frame already uses the freshly sampled pool_en.
  assign mode_cur    = frame_start ? pool_en : mode_q;
  assign col_last    = (col_q == COL_LAST);
  assign row_last    = (row_q == ROW_LAST);
  assign lb_addr     = ADDR_W'(col_q >> 1);

  assign pair_max = ($signed(in_data) > $signed(pair_q)) ? in_data : pair_q;
  assign win_max  = (pair_max > $signed(lb_rd)) ? pair_max : lb_rd;

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (FMAP_W / 2),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_we),
    .addr    (lb_addr),
    .wr_data (pair_max),
    .rd_data (lb_rd)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    mode_d       = mode_q;
    pair_d       = pair_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
    lb_we        = 1'b0;
    result       = in_data;
    out_valid_d  = out_valid_q && !out_ready;
    out_data_d   = out_data_q;

    if (accept) begin
      if (frame_start) mode_d = pool_en;
      col_d = col_last ? '0 : col_q + COL_W'(1);
      if (col_last) row_d = row_last ? '0 : row_q + ROW_W'(1);
      busy_d       = !(col_last && row_last);
      frame_done_d = col_last && row_last;

      if (mode_cur == MODE_BYPASS) begin
        load = 1'b1;
      end else if (!col_q[0]) begin
        pair_d = in_data;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        load   = 1'b1;
        result = win_max;
      end
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= MODE_POOL;
      pair_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      mode_q       <= mode_d;
      pair_q       <= pair_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/maxpool2x2_pe.md
Name: maxpool2x2_pe

Overview:
- Streaming 2x2 stride-2 max-pooling stage directly downstream of the ReLU PE.
- Consumes the post-ReLU output-buffer stream in row-major order, one feature map (FMAP_H x FMAP_W) per frame.
- Emits one pooled value per 2x2 window, or passes samples through unchanged in bypass mode.
- Uses a half-row line buffer plus a valid/ready handshake on both sides.

Parameters:
- DATA_W, `OUTPUT_BUF_DATASIZE: sample width, two's-complement signed.
- FMAP_W, 8: samples per row. Must be even and >= 2.
- FMAP_H, 8: rows per frame. Must be even and >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pool_en  in  1  1 = 2x2 max-pool, 0 = bypass. Captured at frame start only.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  ReLU output sample.
- out_valid  out  1  pooled or bypassed result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  result.
- busy  out  1  frame in progress (any sample of the current frame accepted, frame not finished).
- frame_done  out  1  one-cycle pulse; asserts in the cycle out_valid first presents the frame's final result.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, out_data=0, busy=0, frame_done=0, col=0, row=0, mode=pool, pair register=0. Line buffer is not reset; it is always written on an even row before it is read.
- Handshake:
  - Input accept = in_valid && in_ready.
  - in_ready = !out_valid || out_ready (single output register, no bubble).
  - Output transfer = out_valid && out_ready. out_data must be held stable while out_valid=1 && out_ready=0.
- Frame start: on an accept with row==0 && col==0, pool_en is latched into mode and busy goes to 1. pool_en is ignored at all other times.
- Counters: col increments on each accept and wraps at FMAP_W-1 to 0, which increments row. row wraps at FMAP_H-1 to 0, which ends the frame.
- Pool mode:
  - Even col: in_data is stored in the pair register.
  - Odd col: m = max(pair, in_data), signed compare.
  - Even row: line_buf[col/2] <= m. No output.
  - Odd row: out_data <= max(m, line_buf[col/2]); out_valid <= 1 on the next edge. Latency is 1 cycle from the accept of the window's 4th sample.
  - Output count per frame = (FMAP_H/2)*(FMAP_W/2).
- Bypass mode: every accepted sample is loaded into out_data with out_valid <= 1, latency 1. Output count = FMAP_H*FMAP_W. Counters still run so frame boundaries and frame_done stay correct.
- out_valid handling:
  - Cleared on an output transfer unless a new result loads in the same cycle.
  - Simultaneous transfer and new load: out_data updates and out_valid stays 1.
- frame_done / busy: frame_done pulses for exactly one cycle, on the edge that loads the last result of the frame. busy clears on that same edge.
- Signed compare: max uses signed comparison; for equal values either operand is taken (same value).
- Reset mid-frame: all state is discarded and the next accepted sample is treated as row 0, col 0.
- in_valid with in_ready=0: no state change.

Decomposition:
- config.v:
  - `OUTPUT_BUF_DATASIZE (existing).
  - New defines `POOL_FMAP_W and `POOL_FMAP_H, used as the defaults for the two frame parameters.
- Sub-module pool_line_buf: FMAP_W/2 x DATA_W register array, one write port and one asynchronous read port, both addressed by col/2. No reset.
- Top level holds the counters, mode latch, pair register, signed max logic, output register and handshake.

Test Plan:
1. Pool, 4x4 frame, out_ready=1, rows [1,5,2,0] [3,4,9,1] [0,0,7,7] [2,8,6,6] -> outputs 5, 9, 8, 7 in order; frame_done coincides with the 7; busy falls on that same edge.
2. Pool, signed: window [-3,2 / -1,-4] -> 2; window [-5,-2 / -7,-9] -> -2.
3. Backpressure: scenario 1 with out_ready=0 for 5 cycles after the first out_valid -> in_ready=0 throughout, out_data held at 5, no sample lost; output sequence still 5, 9, 8, 7.
4. Bypass: pool_en=0 at frame start, 4x4 frame of values 0..15 -> 16 outputs 0..15, each 1 cycle after accept; frame_done with the 15.
5. Mode latch: pool_en=1 at frame start, toggled to 0 after 3 samples, scenario-1 data -> still 4 pooled outputs 5, 9, 8, 7.
6. Reset mid-frame: assert rst after 6 accepted samples with out_valid=1 -> out_valid, busy and counters clear immediately. The following full scenario-1 frame yields 5, 9, 8, 7.
